detect_sched: RTL and testbench

//  Round-robin scheduler sharing one A/B sequence detector (Moore FSM: A then B -> Q=1) among N_REQ

---
 rtl/detect_sched.sv | 143 ++++++++++++++
 tb/tb_detect_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/detect_sched.sv
// Round-robin scheduler that time-shares one A/B sequence detector among N_REQ requesters.
// Optional macro HIT_CNT_EN adds per-channel saturating hit counters on port hit_cnt.
module detect_sched #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] a_in,
    input  logic [N_REQ-1:0] b_in,
    input  logic             det_q,
    output logic             det_a,
    output logic             det_b,
    output logic             det_clr,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] hit,
    output logic [N_REQ-1:0] tmo,
    output logic             busy
`ifdef HIT_CNT_EN
    ,
    output logic [N_REQ*CNT_W-1:0] hit_cnt
`endif
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RELEASE} state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     g;
    logic [TW-1:0]     timer;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     off;
    logic [PW:0]       sum;
    logic [2*N_REQ-1:0] rot;
    logic [PW-1:0]     ptr_nxt;
    logic              run_hit;

    if (N_REQ < 2 || TIMEOUT < 3 || CNT_W < 1) begin : g_bad_cfg
        $error("detect_sched: parameter out of range");
    end

    // Rotate requests so the search starts at ptr; lowest set bit of the rotated vector wins.
    always_comb begin
        rot = {req, req} >> ptr;
        off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = PW'(j);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        sel = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ)) : PW'(sum);
    end

    assign ptr_nxt = (g == PW'(N_REQ - 1)) ? '0 : g + 1'b1;
    assign run_hit = (state == RUN) && det_q;

    // Steering is purely combinational so the detector sees stimulus in the same RUN cycle.
    assign det_a = (state == RUN) && a_in[g];
    assign det_b = (state == RUN) && b_in[g];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            g       <= '0;
            timer   <= '0;
            gnt     <= '0;
            hit     <= '0;
            tmo     <= '0;
            det_clr <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    hit <= '0;
                    tmo <= '0;
                    if (|req) begin
                        g       <= sel;
                        gnt     <= N_REQ'(1) << sel;
                        det_clr <= 1'b1;
                        busy    <= 1'b1;
                        state   <= CLEAR;
                    end else begin
                        gnt     <= '0;
                        det_clr <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                CLEAR: begin
                    det_clr <= 1'b0;
                    timer   <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    timer <= timer + 1'b1;
                    // Hit outranks timeout, which outranks a requester abort.
                    if (det_q) begin
                        hit   <= gnt;
                        gnt   <= '0;
                        state <= RELEASE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        tmo   <= gnt;
                        gnt   <= '0;
                        state <= RELEASE;
                    end else if (!req[g]) begin
                        gnt   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    hit   <= '0;
                    tmo   <= '0;
                    busy  <= 1'b0;
                    ptr   <= ptr_nxt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HIT_CNT_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (run_hit && (g == PW'(i)) && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end
        assign hit_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`else
    logic unused_hit;
    assign unused_hit = run_hit;
`endif

endmodule

// File: tb/tb_detect_sched.sv
// Self-checking bench for detect_sched: directed scenarios plus randomized grants checked
// against a transaction-level round-robin/exit-priority model.
module tb_detect_sched;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req, a_in, b_in, gnt, hit, tmo;
    logic         det_q, det_a, det_b, det_clr, busy;
`ifdef HIT_CNT_EN
    logic [N*CW-1:0] hit_cnt;
    int m_hits[N];
`endif

    int checks   = 0;
    int failures = 0;
    int m_ptr    = 0;

    detect_sched #(.N_REQ(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .det_q(det_q),
        .det_a(det_a), .det_b(det_b), .det_clr(det_clr), .gnt(gnt), .hit(hit), .tmo(tmo),
        .busy(busy)
`ifdef HIT_CNT_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Next channel to serve: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    // One full grant: IDLE -> CLEAR -> RUN... -> RELEASE -> IDLE. Entered during an IDLE cycle.
    task automatic transaction(input logic [N-1:0] rq, input int hit_at, input int drop_at,
                               output int ch);
        int g;
        bit done;
        logic [N-1:0] exp_hit, exp_tmo, one;
        g   = pick(rq);
        ch  = g;
        one = N'(1) << g;
        req = rq; a_in = '0; b_in = '0; det_q = 1'($urandom_range(0, 1));
        tick();
        check("clear_gnt", gnt, one);
        check("clear_det_clr", det_clr, 1);
        check("clear_busy", busy, 1);
        a_in = '1; b_in = '1; det_q = 1'($urandom_range(0, 1));
        #1;
        check("clear_det_a", det_a, 0);
        check("clear_det_b", det_b, 0);
        tick();
        exp_hit = '0; exp_tmo = '0; done = 1'b0;
        for (int r = 0; r < TO + 4 && !done; r++) begin
            a_in   = N'($urandom);
            b_in   = N'($urandom);
            req    = N'($urandom);
            req[g] = !(drop_at >= 0 && r >= drop_at);
            det_q  = (r == hit_at);
            #1;
            check("run_det_a", det_a, a_in[g]);
            check("run_det_b", det_b, b_in[g]);
            check("run_gnt", gnt, one);
            check("run_det_clr", det_clr, 0);
            if (det_q) begin
                exp_hit = one; done = 1'b1;
            end else if (r == TO - 1) begin
                exp_tmo = one; done = 1'b1;
            end else if (!req[g]) begin
                done = 1'b1;
            end
            tick();
        end
        check("run_bound", done, 1);
        a_in = '1; b_in = '1; det_q = 1'($urandom_range(0, 1)); req = rq;
        #1;
        check("rel_hit", hit, exp_hit);
        check("rel_tmo", tmo, exp_tmo);
        check("rel_gnt", gnt, 0);
        check("rel_busy", busy, 1);
        check("rel_det_a", det_a, 0);
`ifdef HIT_CNT_EN
        if (exp_hit != 0 && m_hits[g] < (1 << CW) - 1) m_hits[g]++;
        for (int i = 0; i < N; i++) check("hit_cnt", hit_cnt[i*CW +: CW], m_hits[i]);
`endif
        m_ptr = (g + 1) % N;
        tick();
        check("idle_busy", busy, 0);
        check("idle_gnt", gnt, 0);
        check("idle_hit", hit, 0);
        check("idle_tmo", tmo, 0);
    endtask

    initial begin
        int ch;
        logic [N-1:0] rq;
        reset = 1'b0; req = '0; a_in = '0; b_in = '0; det_q = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_det_clr", det_clr, 0);
        check("rst_hit_tmo", {hit, tmo}, 0);
        reset = 1'b1;

        // Idle with no requests; detector Q noise must be ignored.
        for (int k = 0; k < 10; k++) begin
            det_q = 1'($urandom_range(0, 1));
            tick();
            check("idle_gnt0", gnt, 0);
            check("idle_busy0", busy, 0);
            check("idle_clr0", det_clr, 0);
        end

        // Everyone requesting, everyone times out: strict rotation from channel 0.
        for (int k = 0; k < 5; k++) begin
            transaction(4'b1111, -1, -1, ch);
            check("rr_order", ch, k % N);
        end

        // Single channel: A,B then Q two cycles later gives a hit; then a plain timeout.
        transaction(4'b0001, 2, -1, ch);
        transaction(4'b0001, -1, -1, ch);

        // Abort on dropped request, pointer moves past it; hit wins over coincident timeout.
        transaction(4'b0010, -1, 3, ch);
        transaction(4'b1111, TO - 1, -1, ch);
        check("ptr_after_abort", ch, 2);

        for (int k = 0; k < 25; k++) begin
            rq = N'($urandom_range(1, (1 << N) - 1));
            transaction(rq, $urandom_range(0, TO + 3) - 1, $urandom_range(0, 2*TO) - 1, ch);
        end

`ifdef HIT_CNT_EN
        for (int k = 0; k < 3; k++) begin
            transaction(4'b0100, 1, -1, ch);
        end
`endif

        // Asynchronous reset in the middle of a run.
        req = 4'b0100;
        tick(); tick(); tick();
        a_in = '1; b_in = '1;
        #1;
        check("pre_rst_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_det_a", det_a, 0);
        check("mid_rst_det_b", det_b, 0);
        check("mid_rst_clr", det_clr, 0);
        tick();
        reset = 1'b1;
        m_ptr = 0;
`ifdef HIT_CNT_EN
        for (int i = 0; i < N; i++) m_hits[i] = 0;
`endif
        transaction(4'b1111, 4, -1, ch);
        check("post_rst_ptr", ch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
